// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small input FIFO: start bit, LSB-first data,
// optional parity, 1 or 2 stop bits, frames kept back-to-back while data is queued.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] data);
    return (PARITY_ODD != 0) ? ~^data : ^data;
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  state_e               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 serial_q;

  logic                 push_s, pop_s, baud_end_s, fifo_empty_s;
  logic [DATA_BITS-1:0] head_s;

  assign fifo_empty_s = (count_q == '0);
  assign baud_end_s   = (baud_q == BAUD_LAST);
  assign tx_ready     = (count_q != FULL_CNT);
  assign push_s       = tx_valid & tx_ready;
  // A word leaves the FIFO when the line is idle or exactly as the last stop bit ends.
  assign pop_s        = ~fifo_empty_s &
                        ((state_q == ST_IDLE) |
                         ((state_q == ST_STOP) & baud_end_s & (bit_q == STOP_LAST)));
  assign head_s       = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Frame sequencer with registered line output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          bit_q  <= 4'd0;
          if (pop_s) begin
            shift_q  <= head_s;
            par_q    <= frame_parity(head_s);
            state_q  <= ST_START;
            serial_q <= 1'b0;
          end else begin
            serial_q <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_end_s) begin
            baud_q   <= '0;
            bit_q    <= 4'd0;
            state_q  <= ST_DATA;
            serial_q <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_end_s) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q <= 4'd0;
              if (PARITY_EN != 0) begin
                state_q  <= ST_PARITY;
                serial_q <= par_q;
              end else begin
                state_q  <= ST_STOP;
                serial_q <= 1'b1;
              end
            end else begin
              bit_q    <= bit_q + 4'd1;
              serial_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          if (baud_end_s) begin
            baud_q   <= '0;
            bit_q    <= 4'd0;
            state_q  <= ST_STOP;
            serial_q <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_end_s) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= 4'd0;
              if (pop_s) begin
                shift_q  <= head_s;
                par_q    <= frame_parity(head_s);
                state_q  <= ST_START;
                serial_q <= 1'b0;
              end else begin
                state_q  <= ST_IDLE;
                serial_q <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          baud_q   <= '0;
          bit_q    <= 4'd0;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  assign serial_out = serial_q;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign fifo_count = count_q;

endmodule
